// File: rtl/tetris_move_sched_if.sv
// Handshake and control bundle between the move scheduler and the game inputs/datapath.
// master: the scheduler; slave: the surrounding game inputs and datapath blocks.
interface tetris_move_sched_if;
  logic       tick;
  logic       btn_left;
  logic       btn_right;
  logic       btn_rot;
  logic       btn_drop;
  logic       en_newgame;
  logic       move_req;
  logic [1:0] move_op;
  logic       move_done;
  logic       move_ok;
  logic       lock_req;
  logic       lock_done;
  logic       spawn_req;
  logic       spawn_done;
  logic       spawn_fail;
  logic       clear_req;
  logic       clear_done;
  logic       playing;
  logic       game_over;
  logic       err_timeout;
  logic [7:0] drop_rows;

  modport master (
    input  tick, btn_left, btn_right, btn_rot, btn_drop, en_newgame,
    input  move_done, move_ok, lock_done, spawn_done, spawn_fail, clear_done,
    output move_req, move_op, lock_req, spawn_req, clear_req,
    output playing, game_over, err_timeout, drop_rows
  );

  modport slave (
    output tick, btn_left, btn_right, btn_rot, btn_drop, en_newgame,
    output move_done, move_ok, lock_done, spawn_done, spawn_fail, clear_done,
    input  move_req, move_op, lock_req, spawn_req, clear_req,
    input  playing, game_over, err_timeout, drop_rows
  );
endinterface

// File: rtl/tetris_move_sched.sv
// Tetris move scheduler: latches move requests, arbitrates them and sequences clear/spawn/play/lock.
// Define TETRIS_HARD_DROP_EN to enable hard drop (btn_drop, drop_active, drop_rows).
module tetris_move_sched #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                 clk,
  input logic                 rst,
  tetris_move_sched_if.master bus
);
  localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    OP_DOWN    = 2'd0;
  localparam logic [1:0]    OP_LEFT    = 2'd1;
  localparam logic [1:0]    OP_RIGHT   = 2'd2;
  localparam logic [1:0]    OP_ROT     = 2'd3;

  // state | meaning
  // IDLE  | after reset, waiting for new game
  // CLEAR | clearing the grid
  // SPAWN | generating a new piece
  // PLAY  | arbitrating pending moves
  // MOVE  | move command outstanding
  // LOCK  | committing the piece into the grid
  // OVER  | game over, waiting for new game
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SPAWN, S_PLAY, S_MOVE, S_LOCK, S_OVER
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic [1:0]    op, op_nxt;
  logic          err_flag;
  logic          prev_tick, prev_left, prev_right, prev_rot, prev_newgame;
  logic          edge_tick, edge_left, edge_right, edge_rot, edge_newgame;
  logic          p_grav, p_left, p_right, p_rot, p_drop, drop_active;
  logic          grant_grav, grant_left, grant_right, grant_rot, grant_drop;
  logic          timeout, flush, enter_clear, enter_lock;
  logic [7:0]    drop_rows;

  assign edge_tick    = bus.tick & ~prev_tick;
  assign edge_left    = bus.btn_left & ~prev_left;
  assign edge_right   = bus.btn_right & ~prev_right;
  assign edge_rot     = bus.btn_rot & ~prev_rot;
  assign edge_newgame = bus.en_newgame & ~prev_newgame;

  assign flush       = (state == S_IDLE) || (state == S_CLEAR) || (state == S_OVER);
  assign enter_clear = (state_nxt == S_CLEAR) && (state != S_CLEAR);
  assign enter_lock  = (state_nxt == S_LOCK) && (state != S_LOCK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      op           <= OP_DOWN;
      timer        <= TIMER_LOAD;
      err_flag     <= 1'b0;
      prev_tick    <= 1'b0;
      prev_left    <= 1'b0;
      prev_right   <= 1'b0;
      prev_rot     <= 1'b0;
      prev_newgame <= 1'b0;
    end else begin
      state        <= state_nxt;
      op           <= op_nxt;
      prev_tick    <= bus.tick;
      prev_left    <= bus.btn_left;
      prev_right   <= bus.btn_right;
      prev_rot     <= bus.btn_rot;
      prev_newgame <= bus.en_newgame;
      // Wait timer restarts on every state change; terminal count is zero.
      if (state_nxt != state) timer <= TIMER_LOAD;
      else if (timer != '0)   timer <= timer - 1'b1;
      if (timeout)          err_flag <= 1'b1;
      else if (enter_clear) err_flag <= 1'b0;
    end
  end

  always_comb begin
    state_nxt   = state;
    op_nxt      = op;
    timeout     = 1'b0;
    grant_grav  = 1'b0;
    grant_left  = 1'b0;
    grant_right = 1'b0;
    grant_rot   = 1'b0;
    grant_drop  = 1'b0;
    case (state)
      S_IDLE: if (edge_newgame) state_nxt = S_CLEAR;
      S_CLEAR: begin
        if (bus.clear_done)      state_nxt = S_SPAWN;
        else if (timer == '0) begin state_nxt = S_OVER; timeout = 1'b1; end
      end
      S_SPAWN: begin
        if (bus.spawn_done)      state_nxt = bus.spawn_fail ? S_OVER : S_PLAY;
        else if (timer == '0) begin state_nxt = S_OVER; timeout = 1'b1; end
      end
      S_PLAY: begin
        if (drop_active) begin
          op_nxt = OP_DOWN; state_nxt = S_MOVE;
        end else if (p_grav) begin
          grant_grav = 1'b1; op_nxt = OP_DOWN; state_nxt = S_MOVE;
        end else if (p_drop) begin
          grant_drop = 1'b1; op_nxt = OP_DOWN; state_nxt = S_MOVE;
        end else if (p_rot) begin
          grant_rot = 1'b1; op_nxt = OP_ROT; state_nxt = S_MOVE;
        end else if (p_left) begin
          grant_left = 1'b1; op_nxt = OP_LEFT; state_nxt = S_MOVE;
        end else if (p_right) begin
          grant_right = 1'b1; op_nxt = OP_RIGHT; state_nxt = S_MOVE;
        end
      end
      S_MOVE: begin
        if (bus.move_done)       state_nxt = (op == OP_DOWN && !bus.move_ok) ? S_LOCK : S_PLAY;
        else if (timer == '0) begin state_nxt = S_OVER; timeout = 1'b1; end
      end
      S_LOCK: begin
        if (bus.lock_done)       state_nxt = S_SPAWN;
        else if (timer == '0) begin state_nxt = S_OVER; timeout = 1'b1; end
      end
      S_OVER: if (edge_newgame) state_nxt = S_CLEAR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A same-cycle edge wins over the grant so no request is lost.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      p_grav  <= 1'b0;
      p_left  <= 1'b0;
      p_right <= 1'b0;
      p_rot   <= 1'b0;
    end else begin
      p_grav  <= enter_lock ? 1'b0 : (edge_tick | (p_grav & ~grant_grav));
      p_left  <= edge_left  | (p_left  & ~grant_left);
      p_right <= edge_right | (p_right & ~grant_right);
      p_rot   <= edge_rot   | (p_rot   & ~grant_rot);
    end
  end

`ifdef TETRIS_HARD_DROP_EN
  logic prev_drop, edge_drop, drop_step;
  assign edge_drop = bus.btn_drop & ~prev_drop;
  assign drop_step = (state == S_MOVE) && bus.move_done && bus.move_ok &&
                     (op == OP_DOWN) && drop_active;

  // drop_active also dies with the game so a stale drop cannot leak into the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_drop   <= 1'b0;
      p_drop      <= 1'b0;
      drop_active <= 1'b0;
      drop_rows   <= 8'd0;
    end else begin
      prev_drop <= bus.btn_drop;
      if (flush) p_drop <= 1'b0;
      else       p_drop <= edge_drop | (p_drop & ~grant_drop);
      if (flush || enter_lock) drop_active <= 1'b0;
      else if (grant_drop)     drop_active <= 1'b1;
      if (enter_clear)                         drop_rows <= 8'd0;
      else if (drop_step && drop_rows != 8'hFF) drop_rows <= drop_rows + 8'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = ^{bus.btn_drop, grant_drop};
  assign p_drop      = 1'b0;
  assign drop_active = 1'b0;
  assign drop_rows   = 8'd0;
`endif

  assign bus.move_req    = (state == S_MOVE);
  assign bus.move_op     = op;
  assign bus.lock_req    = (state == S_LOCK);
  assign bus.spawn_req   = (state == S_SPAWN);
  assign bus.clear_req   = (state == S_CLEAR);
  assign bus.playing     = (state == S_PLAY) || (state == S_MOVE);
  assign bus.game_over   = (state == S_OVER);
  assign bus.err_timeout = err_flag;
  assign bus.drop_rows   = drop_rows;
endmodule

// File: tb/tb_tetris_move_sched.sv
// Self-checking bench for tetris_move_sched: directed game flow plus randomized move bursts
// checked against a priority-list model of the pending requests.
module tb_tetris_move_sched;
  localparam int TO = 255;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_rows;
  int   cnt, guard;
  logic [1:0] ops[$];
  logic [1:0] cur_op;
  logic [3:0] bits;
  logic       ok;

  tetris_move_sched_if bus ();
  tetris_move_sched #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.move_req;
      1:       return bus.lock_req;
      2:       return bus.spawn_req;
      default: return bus.clear_req;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string tag);
    int n = 0;
    while (sig(sel) !== 1'b1 && n < 600) begin step(); n++; end
    chk(tag, 32'(sig(sel)), 32'd1);
  endtask

  task automatic pulse_done(input int sel, input logic fail);
    case (sel)
      1:       bus.lock_done = 1'b1;
      2:       begin bus.spawn_done = 1'b1; bus.spawn_fail = fail; end
      default: bus.clear_done = 1'b1;
    endcase
    step();
    bus.lock_done = 1'b0; bus.spawn_done = 1'b0; bus.spawn_fail = 1'b0; bus.clear_done = 1'b0;
  endtask

  task automatic serve_move(input logic [1:0] op, input logic okv, input int lat, input string tag);
    wait_for(0, {tag, "_req"});
    chk({tag, "_op"}, 32'(bus.move_op), 32'(op));
    for (int i = 0; i < lat; i++) begin
      step();
      chk({tag, "_hold"}, 32'({bus.move_req, bus.move_op}), 32'({1'b1, op}));
    end
    bus.move_done = 1'b1; bus.move_ok = okv;
    step();
    bus.move_done = 1'b0; bus.move_ok = 1'b0;
    chk({tag, "_fall"}, 32'(bus.move_req), 32'd0);
  endtask

  task automatic new_game();
    bus.en_newgame = 1'b1;
    step();
    bus.en_newgame = 1'b0;
    chk("ng_clear_req", 32'(bus.clear_req), 32'd1);
    chk("ng_err_clr", 32'(bus.err_timeout), 32'd0);
    chk("ng_rows_clr", 32'(bus.drop_rows), 32'd0);
    pulse_done(3, 1'b0);
    chk("ng_spawn_req", 32'(bus.spawn_req), 32'd1);
    pulse_done(2, 1'b0);
    chk("ng_playing", 32'({bus.playing, bus.spawn_req}), 32'b10);
  endtask

  initial begin
    rst = 1'b1;
    {bus.tick, bus.btn_left, bus.btn_right, bus.btn_rot, bus.btn_drop, bus.en_newgame} = '0;
    {bus.move_done, bus.move_ok, bus.lock_done, bus.spawn_done, bus.spawn_fail, bus.clear_done} = '0;
    repeat (3) step();
    chk("rst_reqs", 32'({bus.move_req, bus.lock_req, bus.spawn_req, bus.clear_req}), 32'd0);
    chk("rst_flags", 32'({bus.playing, bus.game_over, bus.err_timeout}), 32'd0);
    chk("rst_op_rows", 32'({bus.move_op, bus.drop_rows}), 32'd0);
    rst = 1'b0;
    step();

    // Game start; nothing should be pending once in PLAY.
    new_game();
    repeat (3) step();
    chk("play_quiet", 32'(bus.move_req), 32'd0);

    // Stray done pulses outside their wait state are ignored.
    bus.move_done = 1'b1; bus.lock_done = 1'b1; bus.spawn_done = 1'b1; bus.spawn_fail = 1'b1;
    bus.clear_done = 1'b1;
    step();
    {bus.move_done, bus.lock_done, bus.spawn_done, bus.spawn_fail, bus.clear_done} = '0;
    step();
    chk("stray_done", 32'({bus.playing, bus.game_over, bus.lock_req, bus.spawn_req, bus.clear_req}),
        32'b10000);

    // Same-cycle tick and left: DOWN first, then LEFT; req at n+2.
    bus.tick = 1'b1; bus.btn_left = 1'b1;
    step();
    bus.tick = 1'b0; bus.btn_left = 1'b0;
    chk("lat_n1", 32'(bus.move_req), 32'd0);
    step();
    chk("lat_n2", 32'(bus.move_req), 32'd1);
    serve_move(2'd0, 1'b1, 1, "tl_down");
    chk("gap_play", 32'({bus.move_req, bus.playing}), 32'b01);
    serve_move(2'd1, 1'b1, 0, "tl_left");

    // Blocked DOWN locks, then a failed spawn ends the game.
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    serve_move(2'd0, 1'b0, 2, "blk_down");
    wait_for(1, "blk_lock");
    pulse_done(1, 1'b0);
    chk("blk_spawn", 32'(bus.spawn_req), 32'd1);
    pulse_done(2, 1'b1);
    chk("over", 32'({bus.game_over, bus.playing, bus.spawn_req}), 32'b100);

    new_game();
`ifdef TETRIS_HARD_DROP_EN
    bus.btn_drop = 1'b1;
    step();
    bus.btn_drop = 1'b0;
    for (int i = 0; i < 4; i++) serve_move(2'd0, 1'b1, i % 2, "hd_row");
    serve_move(2'd0, 1'b0, 0, "hd_last");
    chk("hd_rows", 32'(bus.drop_rows), 32'd4);
    wait_for(1, "hd_lock");
    pulse_done(1, 1'b0);
    pulse_done(2, 1'b0);
    exp_rows = 4;
`else
    bus.btn_drop = 1'b1;
    step();
    bus.btn_drop = 1'b0;
    repeat (4) step();
    chk("nodrop_ignored", 32'(bus.move_req), 32'd0);
    exp_rows = 0;
`endif
    repeat (2) step();
    chk("after_drop", 32'({bus.playing, bus.move_req}), 32'b10);

    // Randomized bursts: expected order is a priority list over the requests raised.
    for (int r = 0; r < 40; r++) begin
      bits = 4'($urandom_range(1, 15));
      bus.tick = bits[0]; bus.btn_rot = bits[1]; bus.btn_left = bits[2]; bus.btn_right = bits[3];
      step();
      bus.tick = 1'b0; bus.btn_rot = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0;
      ops = {};
      if (bits[0]) ops.push_back(2'd0);
      if (bits[1]) ops.push_back(2'd3);
      if (bits[2]) ops.push_back(2'd1);
      if (bits[3]) ops.push_back(2'd2);
      while (ops.size() > 0) begin
        cur_op = ops.pop_front();
        ok = 1'($urandom_range(0, 1));
        serve_move(cur_op, ok, int'($urandom_range(0, 3)), "rnd");
        if (cur_op == 2'd0 && !ok) begin
          wait_for(1, "rnd_lock");
          pulse_done(1, 1'b0);
          wait_for(2, "rnd_spawn");
          pulse_done(2, 1'b0);
        end
      end
      repeat (3) step();
      chk("rnd_quiet", 32'({bus.move_req, bus.playing}), 32'b01);
      chk("rnd_rows", 32'(bus.drop_rows), 32'(exp_rows));
    end

    // Missing move_done: req stays up for exactly TO cycles, then timeout.
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    wait_for(0, "to_req");
    cnt = 1; guard = 0;
    while (guard < 600) begin
      step();
      guard++;
      if (!bus.move_req) break;
      cnt++;
    end
    chk("to_cycles", 32'(cnt), 32'(TO));
    chk("to_flags", 32'({bus.err_timeout, bus.game_over, bus.playing}), 32'b110);
    chk("to_rows_hold", 32'(bus.drop_rows), 32'(exp_rows));
    new_game();

    // Reset in the middle of an outstanding move.
`ifdef TETRIS_HARD_DROP_EN
    bus.btn_drop = 1'b1;
    step();
    bus.btn_drop = 1'b0;
    serve_move(2'd0, 1'b1, 0, "rst_row");
    serve_move(2'd0, 1'b1, 0, "rst_row");
    wait_for(0, "rst_req");
    chk("rst_rows_pre", 32'(bus.drop_rows), 32'd2);
`else
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    wait_for(0, "rst_req");
`endif
    rst = 1'b1;
    step();
    chk("mid_rst", 32'({bus.move_req, bus.playing, bus.drop_rows}), 32'd0);
    rst = 1'b0;
    repeat (3) step();
    chk("post_rst_idle", 32'({bus.move_req, bus.clear_req, bus.game_over, bus.err_timeout}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
